// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity encodings and parity helper
//
// Contents:
//   rx_state_t   receive framer FSM states
//   PAR_EVEN/ODD parity_type encodings
//   calc_parity  expected parity bit for a data word (zero-extend narrow words)
package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP,
      RX_WAIT_IDLE
   } rx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int MAX_DATA_W = 9;

   // Parity bit the transmitter sends; zero padding does not change the XOR.
   function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data,
                                        input logic                  par_type);
      return (^data) ^ (par_type == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with configurable reset value
//
// Ports:
//   clk   in   system clock
//   rstn  in   synchronous active-low reset
//   d     in   asynchronous input
//   q     out  synchronised output (2 clk latency)
module uart_sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive framer with valid/ready output register
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   baud_tick          one-cycle pulse, OVS per bit period
//   rx                 asynchronous serial line, idle high
//   parity_en          1 = parity bit present and checked (latched at start)
//   parity_type        0 = even, 1 = odd (latched at start)
//   data_out           received word, LSB first on the line
//   data_valid         output register holds a frame
//   data_ready         consumer accepts the held frame
//   parity_err         parity mismatch of held frame
//   stop_err           a stop bit sampled 0 in held frame
//   start_err          1-clk pulse on a false start
//   overrun_err        1-clk pulse when a completed frame is dropped
//   busy               FSM not idle
module uart_rx_framer
   import uart_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int OVS       = 16,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              baud_tick,
   input  logic              rx,
   input  logic              parity_en,
   input  logic              parity_type,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              parity_err,
   output logic              stop_err,
   output logic              start_err,
   output logic              overrun_err,
   output logic              busy
);

   localparam int            TW        = $clog2(OVS);
   localparam logic [TW-1:0] HALF_LAST = TW'(OVS / 2 - 1);
   localparam logic [TW-1:0] FULL_LAST = TW'(OVS - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   logic              rx_s;
   rx_state_t         state, state_n;
   logic [TW-1:0]     tick_cnt;
   logic [3:0]        bit_cnt;
   logic [DATA_W-1:0] shift_q;
   logic              par_en_q, par_type_q, par_err_q, stop_acc_q;
   logic              sample, frame_done, false_start, stop_err_n, load;

   uart_sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (rx),
      .q    (rx_s)
   );

   // The start bit is sampled half a bit after detect, every later bit one
   // full bit after the previous sample, which lands mid-bit throughout.
   always_comb begin
      sample = 1'b0;
      if (baud_tick) begin
         case (state)
            RX_START:                    sample = (tick_cnt == HALF_LAST);
            RX_DATA, RX_PARITY, RX_STOP: sample = (tick_cnt == FULL_LAST);
            default:                     sample = 1'b0;
         endcase
      end
   end

   assign stop_err_n = stop_acc_q | ~rx_s;
   assign load       = frame_done & (~data_valid | data_ready);
   assign busy       = (state != RX_IDLE);

   always_comb begin
      state_n     = state;
      frame_done  = 1'b0;
      false_start = 1'b0;
      case (state)
         RX_IDLE:
            if (baud_tick && !rx_s) state_n = RX_START;
         RX_START:
            if (sample) begin
               false_start = rx_s;
               state_n     = rx_s ? RX_IDLE : RX_DATA;
            end
         RX_DATA:
            if (sample && bit_cnt == DATA_LAST)
               state_n = par_en_q ? RX_PARITY : RX_STOP;
         RX_PARITY:
            if (sample) state_n = RX_STOP;
         RX_STOP:
            if (sample && bit_cnt == STOP_LAST) begin
               frame_done = 1'b1;
               // A low line at the end of the frame may be a break; wait for
               // it to return high before hunting for the next start edge.
               state_n    = stop_err_n ? RX_WAIT_IDLE : RX_IDLE;
            end
         RX_WAIT_IDLE:
            if (rx_s) state_n = RX_IDLE;
         default:
            state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= RX_IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         shift_q     <= '0;
         par_en_q    <= 1'b0;
         par_type_q  <= PAR_EVEN;
         par_err_q   <= 1'b0;
         stop_acc_q  <= 1'b0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         parity_err  <= 1'b0;
         stop_err    <= 1'b0;
         start_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         state       <= state_n;
         start_err   <= false_start;
         overrun_err <= frame_done & data_valid & ~data_ready;

         if (state == RX_IDLE) begin
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            par_err_q  <= 1'b0;
            stop_acc_q <= 1'b0;
            if (baud_tick && !rx_s) begin
               par_en_q   <= parity_en;
               par_type_q <= parity_type;
            end
         end else if (baud_tick) begin
            tick_cnt <= sample ? '0 : tick_cnt + TW'(1);
         end

         if (sample) begin
            case (state)
               RX_DATA: begin
                  shift_q <= {rx_s, shift_q[DATA_W-1:1]};
                  bit_cnt <= (bit_cnt == DATA_LAST) ? 4'd0 : bit_cnt + 4'd1;
               end
               RX_PARITY:
                  par_err_q <= calc_parity(MAX_DATA_W'(shift_q), par_type_q) ^ rx_s;
               RX_STOP: begin
                  stop_acc_q <= stop_err_n;
                  bit_cnt    <= bit_cnt + 4'd1;
               end
               default: ;
            endcase
         end

         if (load) begin
            data_out   <= shift_q;
            parity_err <= par_err_q;
            stop_err   <= stop_err_n;
            data_valid <= 1'b1;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - self-checking bench for uart_rx_framer
module tb_uart_rx_framer;

   localparam int BIT_CLKS   = 64;
   localparam int DONE_TICKS = 8 + 16 * 9;

   typedef struct {
      logic [7:0] data;
      bit         pen;
      bit         ptype;
      bit         pbit;
      logic [7:0] exp_data;
      bit         exp_perr;
      bit         exp_serr;
   } vec_t;

   typedef struct {
      logic [7:0] d;
      bit         pe;
      bit         se;
   } exp_t;

   logic       clk, rstn, rstn2, baud_tick, rx, rx2;
   logic       parity_en, parity_type, data_ready, data_ready2;
   logic [7:0] data_out, data_out2;
   logic       data_valid, parity_err, stop_err, start_err, overrun_err, busy;
   logic       data_valid2, parity_err2, stop_err2, start_err2, overrun_err2, busy2;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   se_cnt = 0, se_long = 0, ov_cnt = 0, ov_long = 0;
   exp_t exp_q[$];

   uart_rx_framer #(.DATA_W(8), .OVS(16), .STOP_BITS(1)) dut (
      .clk(clk), .rstn(rstn), .baud_tick(baud_tick), .rx(rx),
      .parity_en(parity_en), .parity_type(parity_type),
      .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
      .parity_err(parity_err), .stop_err(stop_err), .start_err(start_err),
      .overrun_err(overrun_err), .busy(busy)
   );

   uart_rx_framer #(.DATA_W(8), .OVS(16), .STOP_BITS(2)) dut2 (
      .clk(clk), .rstn(rstn2), .baud_tick(baud_tick), .rx(rx2),
      .parity_en(parity_en), .parity_type(parity_type),
      .data_out(data_out2), .data_valid(data_valid2), .data_ready(data_ready2),
      .parity_err(parity_err2), .stop_err(stop_err2), .start_err(start_err2),
      .overrun_err(overrun_err2), .busy(busy2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      int phase;
      phase     = 0;
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         phase     = (phase + 1) % 4;
         baud_tick = (phase == 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input bit pe, input bit se);
      exp_t e;
      e.d = d;
      e.pe = pe;
      e.se = se;
      exp_q.push_back(e);
   endtask

   task automatic drive_bit(input bit which, input logic v);
      if (which) rx2 = v;
      else       rx  = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input bit which, input logic [7:0] d, input bit pen,
                             input bit pbit, input logic stopv, input int nstop);
      drive_bit(which, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
      if (pen) drive_bit(which, pbit);
      for (int i = 0; i < nstop; i++) drive_bit(which, stopv);
   endtask

   // Raise data_ready for exactly the cycle whose edge takes the final stop
   // sample of a no-parity frame whose start edge is driven right now.
   task automatic ready_at_done();
      int guard;
      repeat (2) @(posedge clk);
      guard = 0;
      do begin
         @(posedge clk);
         guard++;
      end while (!baud_tick && guard < 16);
      repeat (DONE_TICKS * 4 - 1) @(posedge clk);
      @(negedge clk);
      data_ready = 1'b1;
      @(negedge clk);
      data_ready = 1'b0;
   endtask

   // Scoreboard: sampled 1 time unit before each rising edge.
   initial begin
      bit   se_prev, ov_prev;
      exp_t e;
      se_prev = 1'b0;
      ov_prev = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         if (start_err) begin
            se_cnt++;
            if (se_prev) se_long++;
         end
         if (overrun_err) begin
            ov_cnt++;
            if (ov_prev) ov_long++;
         end
         se_prev = start_err;
         ov_prev = overrun_err;
         if (data_valid && data_ready) begin
            check("sb_frame_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("sb_data", int'(data_out), int'(e.d));
               check("sb_parity_err", int'(parity_err), int'(e.pe));
               check("sb_stop_err", int'(stop_err), int'(e.se));
            end
         end
      end
   end

   initial begin
      vec_t vecs[7];
      int   s0, o0;

      vecs[0] = '{8'h17, 1'b1, 1'b0, 1'b0, 8'h17, 1'b0, 1'b0};
      vecs[1] = '{8'h17, 1'b1, 1'b1, 1'b1, 8'h17, 1'b0, 1'b0};
      vecs[2] = '{8'h17, 1'b1, 1'b1, 1'b0, 8'h17, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0};
      vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};

      rx = 1'b1; rx2 = 1'b1; rstn = 1'b0; rstn2 = 1'b0;
      parity_en = 1'b0; parity_type = 1'b0; data_ready = 1'b0; data_ready2 = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_data_out", int'(data_out), 0);
      check("rst_data_valid", int'(data_valid), 0);
      check("rst_parity_err", int'(parity_err), 0);
      check("rst_stop_err", int'(stop_err), 0);
      check("rst_start_err", int'(start_err), 0);
      check("rst_overrun_err", int'(overrun_err), 0);
      check("rst_busy", int'(busy), 0);
      check("rst2_valid", int'(data_valid2), 0);
      rstn = 1'b1; rstn2 = 1'b1;
      repeat (8) @(negedge clk);

      data_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         parity_en   = vecs[i].pen;
         parity_type = vecs[i].ptype;
         push_exp(vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_serr);
         send_frame(1'b0, vecs[i].data, vecs[i].pen, vecs[i].pbit, 1'b1, 1);
         repeat (32) @(negedge clk);
      end
      check("table_drained", exp_q.size(), 0);

      data_ready = 1'b0; parity_en = 1'b1; parity_type = 1'b0;
      send_frame(1'b0, 8'h17, 1'b1, 1'b0, 1'b1, 1);
      repeat (8) @(negedge clk);
      check("hold_valid", int'(data_valid), 1);
      check("hold_data", int'(data_out), 8'h17);
      check("hold_perr", int'(parity_err), 0);
      check("hold_serr", int'(stop_err), 0);
      repeat (100) @(negedge clk);
      check("hold_valid_late", int'(data_valid), 1);
      check("hold_data_late", int'(data_out), 8'h17);
      push_exp(8'h17, 1'b0, 1'b0);
      data_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("hold_valid_drop", int'(data_valid), 0);
      check("hold_drained", exp_q.size(), 0);

      parity_en = 1'b0;
      s0 = se_cnt;
      rx = 1'b0;
      repeat (12) @(negedge clk);
      check("glitch_busy", int'(busy), 1);
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (60) @(negedge clk);
      check("glitch_start_err", se_cnt - s0, 1);
      check("glitch_no_valid", int'(data_valid), 0);
      check("glitch_busy_idle", int'(busy), 0);

      push_exp(8'h5A, 1'b0, 1'b1);
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1);
      repeat (BIT_CLKS) @(negedge clk);
      check("break_wait_busy", int'(busy), 1);
      repeat (BIT_CLKS) @(negedge clk);
      rx = 1'b1;
      repeat (16) @(negedge clk);
      check("break_busy_idle", int'(busy), 0);
      check("break_one_frame", exp_q.size(), 0);
      push_exp(8'h01, 1'b0, 1'b0);
      send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1);
      repeat (32) @(negedge clk);
      check("after_break_drained", exp_q.size(), 0);

      data_ready = 1'b0;
      o0 = ov_cnt;
      push_exp(8'hA5, 1'b0, 1'b0);
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1);
      repeat (16) @(negedge clk);
      check("ovr_data_kept", int'(data_out), 8'hA5);
      check("ovr_valid", int'(data_valid), 1);
      check("ovr_pulses", ov_cnt - o0, 1);
      data_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("ovr_drained", exp_q.size(), 0);

      data_ready = 1'b0;
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1);
      repeat (16) @(negedge clk);
      check("same_cyc_first", int'(data_out), 8'h11);
      push_exp(8'h11, 1'b0, 1'b0);
      push_exp(8'h22, 1'b0, 1'b0);
      o0 = ov_cnt;
      fork
         send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1);
         ready_at_done();
      join
      repeat (16) @(negedge clk);
      check("same_cyc_data", int'(data_out), 8'h22);
      check("same_cyc_valid", int'(data_valid), 1);
      check("same_cyc_no_ovr", ov_cnt - o0, 0);
      check("same_cyc_pending", exp_q.size(), 1);
      data_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("same_cyc_drained", exp_q.size(), 0);

      parity_en = 1'b0;
      send_frame(1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 2);
      repeat (16) @(negedge clk);
      check("s2_held_valid", int'(data_valid2), 1);
      check("s2_held_data", int'(data_out2), 8'h33);
      fork
         send_frame(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 2);
         begin
            repeat (BIT_CLKS * 3) @(negedge clk);
            check("s2_busy_mid", int'(busy2), 1);
            rstn2 = 1'b0;
            @(negedge clk);
            rstn2 = 1'b1;
            check("s2_rst_data", int'(data_out2), 0);
            check("s2_rst_valid", int'(data_valid2), 0);
            check("s2_rst_perr", int'(parity_err2), 0);
            check("s2_rst_serr", int'(stop_err2), 0);
            check("s2_rst_busy", int'(busy2), 0);
         end
      join
      repeat (16) @(negedge clk);
      check("s2_no_partial", int'(data_valid2), 0);
      send_frame(1'b1, 8'h81, 1'b0, 1'b0, 1'b1, 2);
      repeat (16) @(negedge clk);
      check("s2_data", int'(data_out2), 8'h81);
      check("s2_valid", int'(data_valid2), 1);
      check("s2_serr", int'(stop_err2), 0);
      check("s2_perr", int'(parity_err2), 0);
      data_ready2 = 1'b1;
      repeat (2) @(negedge clk);
      check("s2_valid_drop", int'(data_valid2), 0);

      check("start_err_width", se_long, 0);
      check("overrun_err_width", ov_long, 0);
      check("final_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
